// File: rtl/pkt_fifo.sv
// Packet-aware FIFO: writes stay speculative until committed and can be rolled back.
// The read side only ever sees committed data.
module pkt_fifo #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int AFULL_THRESH  = 60,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_commit,
  input  logic              w_abort,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   free,
  output logic              overflow,
  output logic              underflow
);

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_P  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_THRESH);
  localparam ptr_t ONE      = ptr_t'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  ptr_t wr_ptr, cm_ptr, rd_ptr, used;
  logic wa, ra;

  // used counts speculative slots too, so an open packet can fill the FIFO
  assign used         = wr_ptr - rd_ptr;
  assign count        = cm_ptr - rd_ptr;
  assign free         = DEPTH_P - used;
  assign empty        = (cm_ptr == rd_ptr);
  assign full         = (used == DEPTH_P);
  assign almost_full  = (used >= AFULL_P);
  assign almost_empty = (count <= AEMPTY_P);

  assign wa     = w_enable & ~full;
  assign ra     = r_enable & ~empty;
  assign r_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wa && !clear) mem[wr_ptr[ADDR_W-1:0]] <= w_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ra) rd_ptr <= rd_ptr + ONE;
      // abort rewinds to the last commit point and drops this cycle's write
      if (w_abort)      wr_ptr <= cm_ptr;
      else if (wa)      wr_ptr <= wr_ptr + ONE;
      if (w_commit && !w_abort) cm_ptr <= wr_ptr + ptr_t'(wa);
      if (w_enable && full)  overflow  <= 1'b1;
      if (r_enable && empty) underflow <= 1'b1;
    end
  end

endmodule
